// File: rtl/cmd_seq_arbiter_pkg.sv
// Shared types and constants for the command sequencer arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cmd_seq_arbiter_pkg;

   // FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_START     = 3'd1;
   localparam state_t ST_WAIT_BUSY = 3'd2;
   localparam state_t ST_WAIT_DONE = 3'd3;
   localparam state_t ST_GAP       = 3'd4;

   // Saturating merged-request counter
   localparam int                   DROP_CNT_W   = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

   // Width of an index into an n-entry vector (at least one bit)
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmd_seq_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set pending bit above the pointer, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid_o is low when nothing is pending.
module rr_priority_select
   import cmd_seq_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  pending_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  winner_o,
   output logic [IW-1:0] winner_idx_o,
   output logic          valid_o
);

   // Scan ptr+1, ptr+2, ... ptr+N (mod N); the last candidate is the pointer itself
   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      winner_o     = '0;
      winner_idx_o = '0;
      valid_o      = 1'b0;
      cand         = 0;
      cand_idx     = '0;
      for (int off = 1; off <= N; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IW'(cand);
         if (!valid_o && pending_i[cand_idx]) begin
            valid_o            = 1'b1;
            winner_idx_o       = cand_idx;
            winner_o[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cmd_seq_arbiter.sv
// Round-robin arbiter sharing one command sequencer; optional wait-busy timeout under CMD_SEQ_ARBITER_TIMEOUT_EN.
// Latency: REQ at cycle n -> PENDING at n+1 -> SEQ_START_FLAG at n+2 when idle and enabled.
// Backpressure: grants held off by ENABLE, SEQ_START_ENABLE, SEQ_READY and the post-transaction gap.
module cmd_seq_arbiter
   import cmd_seq_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int GAP_WIDTH = 16
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                  CMD_CLK,
   input  logic                  CMD_RST,
   input  logic                  ENABLE,
   input  logic [GAP_WIDTH-1:0]  GAP_CYCLES,
   input  logic [NUM_REQ-1:0]    REQ,
   input  logic                  SEQ_START_ENABLE,
   input  logic                  SEQ_READY,
   input  logic                  SEQ_READY_FLAG,
   output logic                  SEQ_START_FLAG,
   output logic [NUM_REQ-1:0]    GRANT,
   output logic [NUM_REQ-1:0]    DONE,
   output logic [NUM_REQ-1:0]    PENDING,
   output logic [DROP_CNT_W-1:0] DROP_CNT,
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
   output logic                  TIMEOUT,
`endif
   output logic                  BUSY
);

   localparam int IW = idx_w(NUM_REQ);

   state_t                 state_q, state_d;
   logic [IW-1:0]          ptr_q;
   logic [NUM_REQ-1:0]     pending_q, pending_d;
   logic [NUM_REQ-1:0]     grant_q;
   logic [NUM_REQ-1:0]     done_q;
   logic [DROP_CNT_W-1:0]  drop_q, drop_d;
   logic [GAP_WIDTH-1:0]   gap_q;
   logic                   flag_q;

   logic [NUM_REQ-1:0]     win;
   logic [IW-1:0]          win_idx;
   logic                   win_vld;
   logic [NUM_REQ-1:0]     clr;
   logic [NUM_REQ-1:0]     merged;
   logic [DROP_CNT_W:0]    merged_cnt;
   logic [DROP_CNT_W:0]    drop_sum;

   logic                   grant_go;
   logic                   done_go;
   logic                   to_hit;
   logic                   enter_gap;

   rr_priority_select #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .pending_i    (pending_q),
      .ptr_i        (ptr_q),
      .winner_o     (win),
      .winner_idx_o (win_idx),
      .valid_o      (win_vld)
   );

   assign grant_go  = (state_q == ST_IDLE) && ENABLE && SEQ_START_ENABLE && SEQ_READY && win_vld;
   assign done_go   = (state_q == ST_WAIT_DONE) && SEQ_READY_FLAG;
   assign enter_gap = done_go || to_hit;

`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_q;
   logic            timeout_q;

   // Sequencer never went busy: abandon the transaction after TIMEOUT_CYCLES in WAIT_BUSY
   assign to_hit = (state_q == ST_WAIT_BUSY) && SEQ_READY && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Count cycles spent in WAIT_BUSY; restarts from zero on every entry
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         to_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_q      <= (state_q == ST_WAIT_BUSY) ? to_q + 1'b1 : '0;
         timeout_q <= to_hit;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (grant_go) state_d = ST_START;
         ST_START:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (!SEQ_READY) begin
               state_d = ST_WAIT_DONE;
            end else if (to_hit) begin
               state_d = ST_GAP;
            end
         end
         ST_WAIT_DONE: if (SEQ_READY_FLAG) state_d = ST_GAP;
         ST_GAP:       if (gap_q == '0) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      BUSY           = (state_q != ST_IDLE);
      SEQ_START_FLAG = flag_q;
      GRANT          = grant_q;
      DONE           = done_q;
      PENDING        = pending_q;
      DROP_CNT       = drop_q;
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
      TIMEOUT        = timeout_q;
`endif
   end

   // Request latching: a new request beats the grant clearing the same bit
   always_comb begin
      clr        = grant_go ? win : '0;
      merged     = REQ & pending_q & ~clr;
      pending_d  = (pending_q & ~clr) | REQ;
      merged_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         merged_cnt = merged_cnt + {{DROP_CNT_W{1'b0}}, merged[i]};
      end
      drop_sum = {1'b0, drop_q} + merged_cnt;
      drop_d   = (drop_sum > {1'b0, DROP_CNT_MAX}) ? DROP_CNT_MAX : drop_sum[DROP_CNT_W-1:0];
   end

   // Pending vector and saturating drop counter
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         pending_q <= '0;
         drop_q    <= '0;
      end else begin
         pending_q <= pending_d;
         drop_q    <= drop_d;
      end
   end

   // Owner and round-robin pointer; pointer moves to the winner at grant time
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         grant_q <= '0;
         ptr_q   <= IW'(NUM_REQ - 1);
      end else if (grant_go) begin
         grant_q <= win;
         ptr_q   <= win_idx;
      end else if (enter_gap) begin
         grant_q <= '0;
      end
   end

   // Single-cycle start flag, aligned with the START state
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= (state_d == ST_START);
      end
   end

   // Completion pulse on the owner's bit, coincident with entering GAP
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         done_q <= '0;
      end else begin
         done_q <= done_go ? grant_q : '0;
      end
   end

   // Gap counter: GAP_CYCLES sampled only on entry, counts down to zero and holds
   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         gap_q <= '0;
      end else if (enter_gap) begin
         gap_q <= GAP_CYCLES;
      end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
         gap_q <= gap_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_cmd_seq_arbiter.sv
// Self-checking bench for cmd_seq_arbiter with a behavioural sequencer and grant scoreboard.
// Latency: checks start-flag, done and gap timing in absolute cycles.
// Backpressure: exercises ENABLE, SEQ_START_ENABLE blocking and reset mid-transaction.
module tb_cmd_seq_arbiter;

   localparam int N  = 4;
   localparam int GW = 16;

   logic          CMD_CLK = 1'b0;
   logic          CMD_RST;
   logic          ENABLE;
   logic [GW-1:0] GAP_CYCLES;
   logic [N-1:0]  REQ;
   logic          SEQ_START_ENABLE;
   logic          SEQ_READY;
   logic          SEQ_READY_FLAG;
   logic          SEQ_START_FLAG;
   logic [N-1:0]  GRANT;
   logic [N-1:0]  DONE;
   logic [N-1:0]  PENDING;
   logic [7:0]    DROP_CNT;
   logic          BUSY;
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
   logic          TIMEOUT;
`endif

   cmd_seq_arbiter #(
      .NUM_REQ   (N),
      .GAP_WIDTH (GW)
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (15)
`endif
   ) dut (
      .CMD_CLK          (CMD_CLK),
      .CMD_RST          (CMD_RST),
      .ENABLE           (ENABLE),
      .GAP_CYCLES       (GAP_CYCLES),
      .REQ              (REQ),
      .SEQ_START_ENABLE (SEQ_START_ENABLE),
      .SEQ_READY        (SEQ_READY),
      .SEQ_READY_FLAG   (SEQ_READY_FLAG),
      .SEQ_START_FLAG   (SEQ_START_FLAG),
      .GRANT            (GRANT),
      .DONE             (DONE),
      .PENDING          (PENDING),
      .DROP_CNT         (DROP_CNT),
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
      .TIMEOUT          (TIMEOUT),
`endif
      .BUSY             (BUSY)
   );

   always #5 CMD_CLK = ~CMD_CLK;

   int cyc = 0;
   always @(posedge CMD_CLK) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CMD_CLK);
      #1;
   endtask

   // Scoreboard of expected grant owners, in grant order
   int   exp_q[$];
   int   nflags   = 0;
   int   ndone    = 0;
   int   nto      = 0;
   int   flag_cyc = 0;
   int   done_cyc = 0;
   int   to_cyc   = 0;
   int   owner    = 0;
   logic prev_flag = 1'b0;
   int   seq_mode = 0;

   // Monitor: pop expected owner on each start flag, check DONE against the owner
   always @(negedge CMD_CLK) begin
      if (!CMD_RST) begin
         if (SEQ_START_FLAG) begin
            chk("flag_b2b", prev_flag, 0);
            flag_cyc = cyc;
            nflags++;
            if (exp_q.size() == 0) begin
               chk("sb_underflow", exp_q.size(), 1);
            end else begin
               owner = exp_q.pop_front();
               chk("grant_owner", GRANT, 32'(1) << owner);
            end
         end
         if (DONE != '0) begin
            chk("done_owner", DONE, 32'(1) << owner);
            done_cyc = cyc;
            ndone++;
         end
`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
         if (TIMEOUT) begin
            chk("to_no_done", DONE, 0);
            to_cyc = cyc;
            nto++;
         end
`endif
      end
      prev_flag = SEQ_START_FLAG;
   end

   // Sequencer model: busy two cycles after the flag, ready-flag 25 cycles later
   initial begin
      SEQ_READY      = 1'b1;
      SEQ_READY_FLAG = 1'b0;
      forever begin
         @(negedge CMD_CLK);
         if (SEQ_START_FLAG && !CMD_RST && seq_mode == 0) begin
            @(posedge CMD_CLK); #1;
            @(posedge CMD_CLK); #1;
            SEQ_READY = 1'b0;
            repeat (25) @(posedge CMD_CLK);
            #1;
            SEQ_READY      = 1'b1;
            SEQ_READY_FLAG = 1'b1;
            @(posedge CMD_CLK); #1;
            SEQ_READY_FLAG = 1'b0;
         end
      end
   end

   task automatic wait_flags(input int target, input string tag);
      int n = 0;
      while (nflags < target && n < 2000) begin
         tick(1);
         n++;
      end
      chk(tag, (n < 2000), 1);
   endtask

   task automatic wait_quiet(input string tag);
      int n = 0;
      while ((BUSY || PENDING != '0 || exp_q.size() != 0) && n < 3000) begin
         tick(1);
         n++;
      end
      chk(tag, (n < 3000), 1);
   endtask

   task automatic do_reset();
      CMD_RST = 1'b1;
      tick(2);
      CMD_RST = 1'b0;
      tick(1);
   endtask

   initial begin
      int t0, n0, nd0, m, f1, n;
      CMD_RST          = 1'b1;
      ENABLE           = 1'b1;
      GAP_CYCLES       = 16'd3;
      REQ              = '0;
      SEQ_START_ENABLE = 1'b1;
      tick(3);
      @(negedge CMD_CLK);
      chk("rst_grant",   GRANT, 0);
      chk("rst_pending", PENDING, 0);
      chk("rst_busy",    BUSY, 0);
      chk("rst_drop",    DROP_CNT, 0);
      chk("rst_flag",    SEQ_START_FLAG, 0);
      chk("rst_done",    DONE, 0);
      @(posedge CMD_CLK); #1;
      CMD_RST = 1'b0;

      // Single requester timing, with a second request queued behind the gap
      t0 = cyc;
      tick(10);
      REQ = 4'b0001; exp_q.push_back(0);
      tick(1);
      REQ = '0;
      @(negedge CMD_CLK);
      chk("t1_pend_n1", PENDING, 4'b0001);
      while (cyc < t0 + 20) tick(1);
      REQ = 4'b0010; exp_q.push_back(1);
      tick(1);
      REQ = '0;
      while (cyc < t0 + 30) tick(1);
      @(negedge CMD_CLK);
      chk("t1_grant_busy", GRANT, 4'b0001);
      chk("t1_pend_mid",   PENDING, 4'b0010);
      chk("t1_busy",       BUSY, 1);
      chk("t1_flag_cyc",   flag_cyc - t0, 12);
      chk("t1_nflags",     nflags, 1);
      @(posedge CMD_CLK); #1;
      wait_flags(2, "t1_wait2");
      chk("t1_done_cyc",   done_cyc - t0, 40);
      chk("t1_flag2_cyc",  flag_cyc - t0, 45);
      wait_quiet("t1_quiet");

      // Fairness: all four at once, then requester 0 again after its grant
      do_reset();
      n0 = nflags;
      REQ = 4'b1111;
      for (int i = 0; i < N; i++) exp_q.push_back(i);
      tick(1);
      REQ = '0;
      wait_flags(n0 + 1, "fair_w1");
      REQ = 4'b0001; exp_q.push_back(0);
      tick(1);
      REQ = '0;
      wait_quiet("fair_quiet");
      chk("fair_cnt",  nflags - n0, 5);
      chk("fair_drop", DROP_CNT, 0);

      // Merge while disabled, then saturate the drop counter
      do_reset();
      n0 = nflags;
      ENABLE = 1'b0;
      repeat (3) begin
         REQ = 4'b0100;
         tick(1);
         REQ = '0;
         tick(1);
      end
      exp_q.push_back(2);
      @(negedge CMD_CLK);
      chk("merge_pend", PENDING, 4'b0100);
      chk("merge_drop", DROP_CNT, 2);
      chk("merge_busy", BUSY, 0);
      @(posedge CMD_CLK); #1;
      REQ = 4'b1000; exp_q.push_back(3);
      tick(258);
      REQ = '0;
      tick(1);
      @(negedge CMD_CLK);
      chk("sat_drop",   DROP_CNT, 255);
      chk("sat_pend",   PENDING, 4'b1100);
      chk("sat_noflag", nflags - n0, 0);
      @(posedge CMD_CLK); #1;
      ENABLE = 1'b1;
      wait_quiet("merge_quiet");
      chk("merge_grants", nflags - n0, 2);
      chk("sat_hold",     DROP_CNT, 255);

      // Blocking by SEQ_START_ENABLE; re-request on the grant cycle re-pends
      do_reset();
      n0 = nflags;
      SEQ_START_ENABLE = 1'b0;
      REQ = 4'b0001; exp_q.push_back(0);
      tick(1);
      REQ = '0;
      tick(100);
      @(negedge CMD_CLK);
      chk("blk_noflag", nflags - n0, 0);
      chk("blk_pend",   PENDING, 4'b0001);
      chk("blk_busy",   BUSY, 0);
      @(posedge CMD_CLK); #1;
      SEQ_START_ENABLE = 1'b1;
      REQ = 4'b0001; exp_q.push_back(0);
      m = cyc;
      tick(1);
      REQ = '0;
      @(negedge CMD_CLK);
      chk("blk_flag_next", SEQ_START_FLAG, 1);
      chk("blk_flag_cyc",  cyc - m, 1);
      chk("blk_setwins",   PENDING, 4'b0001);
      chk("blk_nodrop",    DROP_CNT, 0);
      @(posedge CMD_CLK); #1;
      wait_quiet("blk_quiet");
      chk("blk_grants", nflags - n0, 2);

      // Reset in WAIT_DONE: everything clears at once, late ready-flag ignored
      do_reset();
      n0  = nflags;
      nd0 = ndone;
      REQ = 4'b0001; exp_q.push_back(0);
      tick(1);
      REQ = 4'b0100;
      tick(1);
      REQ = '0;
      n = 0;
      while (SEQ_READY && n < 100) begin
         tick(1);
         n++;
      end
      chk("rmid_wait", (n < 100), 1);
      tick(3);
      chk("rmid_pre_busy", BUSY, 1);
      CMD_RST = 1'b1;
      #2;
      chk("rmid_grant", GRANT, 0);
      chk("rmid_busy",  BUSY, 0);
      chk("rmid_pend",  PENDING, 0);
      tick(1);
      CMD_RST = 1'b0;
      tick(40);
      chk("rmid_nodone", ndone - nd0, 0);
      chk("rmid_idle",   BUSY, 0);
      chk("rmid_flags",  nflags - n0, 1);

`ifdef CMD_SEQ_ARBITER_TIMEOUT_EN
      // Sequencer never goes busy on the first grant
      do_reset();
      n0  = nflags;
      nd0 = ndone;
      seq_mode = 1;
      REQ = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
      tick(1);
      REQ = '0;
      wait_flags(n0 + 1, "to_w1");
      f1 = flag_cyc;
      seq_mode = 0;
      wait_quiet("to_quiet");
      chk("to_count",     nto, 1);
      chk("to_cyc",       to_cyc - f1, 16);
      chk("to_next_flag", flag_cyc - to_cyc, 5);
      chk("to_done_cnt",  ndone - nd0, 1);
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
